// File: rtl/mod_counter.sv
// Modulo-MODULO up/down counter with wrap/saturate mode, terminal-count pulse and sticky overflow.
// Define MOD_COUNTER_PRESCALE_EN to divide the count enable by PRESCALE.
module mod_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULO   = 16,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             COUNTON,
  input  logic             UP,
  input  logic             SAT,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LDVAL,
  output logic [WIDTH-1:0] CNT,
  output logic             TC,
  output logic             OVF
);

  // Truncation is exact: MODULO <= 2^WIDTH, so MODULO-1 always fits.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_end;

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int unsigned PsW = $clog2(PRESCALE);
  localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);

  logic [PsW-1:0] ps_q, ps_d;
  logic           ps_tick;

  assign ps_tick = (ps_q == PsMax);

  always_comb begin
    ps_d = ps_q;
    if (CLR || LOAD) begin
      ps_d = '0;
    end else if (COUNTON) begin
      ps_d = ps_tick ? '0 : ps_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  assign step = COUNTON & ps_tick & ~CLR & ~LOAD;
`else
  assign step = COUNTON & ~CLR & ~LOAD;
`endif

  assign at_end = UP ? (cnt_q == MaxVal) : (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (CLR) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (LOAD) begin
      cnt_d = (LDVAL > MaxVal) ? MaxVal : LDVAL;
    end else if (step) begin
      tc_d  = at_end;
      ovf_d = ovf_q | at_end;
      if (at_end) begin
        cnt_d = SAT ? cnt_q : (UP ? '0 : MaxVal);
      end else begin
        // Only reached below the range end, so +1/-1 never leaves 0..MODULO-1.
        cnt_d = UP ? cnt_q + 1'b1 : cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign CNT = cnt_q;
  assign TC  = tc_q;
  assign OVF = ovf_q;

endmodule
